// File: rtl/spram_master.sv
// Avalon-MM burst master for a single-port RAM slave (addr-reg / write-enable / auto-increment data port).
// Optional ID verification ahead of every burst when SPRAM_MASTER_ID_CHECK_EN is defined.
module spram_master #(
    parameter int          ADDR_W   = 11,
    parameter logic [31:0] ID_VALUE = 32'h87654321
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [2:0]        avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata
);

    typedef enum logic [3:0] {
        IDLE, ID_RD, ID_CHK, SET_ADDR, SET_WE, WR_WORD,
        CLR_WE, RD_WAIT, RD_ISSUE, RD_CAPT, DONE
    } state_t;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic              r_mode;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_remain;
    logic              r_done;

`ifdef SPRAM_MASTER_ID_CHECK_EN
    logic r_error;
    assign error = r_error;
`else
    logic w_unused_id;
    assign w_unused_id = ^ID_VALUE;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_mode   <= 1'b0;
            r_base   <= '0;
            r_remain <= '0;
            r_done   <= 1'b0;
`ifdef SPRAM_MASTER_ID_CHECK_EN
            r_error  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_base   <= base_addr;
                        r_remain <= count;
`ifdef SPRAM_MASTER_ID_CHECK_EN
                        r_error  <= 1'b0;
                        r_state  <= (count == '0) ? DONE : ID_RD;
`else
                        r_state  <= (count == '0) ? DONE : SET_ADDR;
`endif
                    end
                end
`ifdef SPRAM_MASTER_ID_CHECK_EN
                ID_RD:  r_state <= ID_CHK;
                ID_CHK: begin
                    if (avm_readdata == ID_VALUE) begin
                        r_state <= SET_ADDR;
                    end else begin
                        r_error <= 1'b1;
                        r_state <= DONE;
                    end
                end
`endif
                SET_ADDR: r_state <= r_mode ? RD_WAIT : SET_WE;
                SET_WE:   r_state <= WR_WORD;
                WR_WORD: begin
                    if (in_valid) begin
                        r_remain <= r_remain - ONE;
                        if (r_remain == ONE) r_state <= CLR_WE;
                    end
                end
                CLR_WE:   r_state <= DONE;
                RD_WAIT:  r_state <= RD_ISSUE;
                RD_ISSUE: r_state <= RD_CAPT;
                RD_CAPT: begin
                    r_remain <= r_remain - ONE;
                    r_state  <= (r_remain == ONE) ? DONE : RD_ISSUE;
                end
                DONE: begin
                    // done is registered so it appears the cycle busy falls
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Bus strobes are a pure decode of the state, except the write-data handshake
    always_comb begin
        avm_address   = 3'd0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_writedata = 32'd0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_data      = 32'd0;
        case (r_state)
`ifdef SPRAM_MASTER_ID_CHECK_EN
            ID_RD: begin
                avm_read    = 1'b1;
                avm_address = 3'd3;
            end
`endif
            SET_ADDR: begin
                avm_write     = 1'b1;
                avm_address   = 3'd1;
                avm_writedata = {{(32-ADDR_W){1'b0}}, r_base};
            end
            SET_WE: begin
                avm_write     = 1'b1;
                avm_address   = 3'd2;
                avm_writedata = 32'd1;
            end
            WR_WORD: begin
                in_ready      = 1'b1;
                avm_write     = in_valid;
                avm_writedata = in_valid ? in_data : 32'd0;
            end
            CLR_WE: begin
                avm_write   = 1'b1;
                avm_address = 3'd2;
            end
            RD_ISSUE: avm_read = 1'b1;
            RD_CAPT: begin
                out_valid = 1'b1;
                out_data  = avm_readdata;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;

endmodule
